l1_mac_sequencer: RTL and testbench
===================================

# l1_mac_sequencer

Control FSM that drives the 32-neuron layer-1 MAC array through one 784-pixel inference. It clears the accumulators, loads the biases, and walks a shared pixel/weight read address across a synchronous-read memory. It then presents the finished accumulators to layer 2 with a valid/ready handshake. It sits between the top-level inference controller, the pixel and weight memories, and the MAC array's control inputs.

## Interface
Parameters:
- `N_PIX`, 784, number of pixels (and weight rows) per inference; must be at least 2
- `ADDR_W`, 10, width of the pixel/weight address; 2^ADDR_W ≥ N_PIX

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin an inference; sampled only in IDLE
- `abort`  in  1  synchronous cancel; highest priority after reset
- `busy`  out  1  high in every state except IDLE
- `rd_addr`  out  ADDR_W  pixel index; drives pixel memory and weight-row memory; both have 1-cycle read latency
- `mac_clr`  out  1  to MAC array `clr`
- `mac_init_bias`  out  1  to MAC array `init_bias`
- `mac_en`  out  1  to MAC array `en`; aligned with memory read data
- `out_valid`  out  1  accumulator outputs final and stable
- `out_ready`  in  1  layer 2 has taken the results

## Operation
- States: IDLE → CLEAR → BIAS → RUN → DRAIN → VALID → IDLE.
- IDLE: all outputs are 0. `start`=1 moves to CLEAR.
- CLEAR, one cycle: `mac_clr`=1.
- BIAS, one cycle: `mac_init_bias`=1 and `rd_addr`=0 (first read issued). Index counter is loaded with 1.
- RUN: `rd_addr`=counter, then the counter increments. On the cycle that issues address N_PIX−1, the FSM moves to DRAIN.
- `rd_vld` register: set on any cycle that issues an address (BIAS, RUN), otherwise 0. `mac_en` = `rd_vld`. This gives exactly N_PIX `mac_en` cycles.
- DRAIN, one cycle: `mac_en`=1 for the last pixel; no address is issued.
- VALID: `out_valid`=1 and all MAC controls are 0. Move to IDLE on the cycle where `out_valid` and `out_ready` are both 1.
- `rd_addr` holds its last value outside BIAS/RUN. It is don't-care for memories but must be deterministic: 0 after reset.
- `abort`=1 in any state: next state is IDLE, `rd_vld` is cleared, and no `mac_en` is asserted on the following cycle. Accumulator contents are then undefined until the next CLEAR.
- `start` while busy is ignored; no queueing. `start` and `abort` together in IDLE: stay in IDLE.
- No arithmetic beyond the ADDR_W-bit counter. The counter never wraps because RUN exits at N_PIX−1.

## Timing
- Reset (`rst`=0, async): state IDLE, counter 0, `rd_addr`=0, `rd_vld`=0, and every output 0. Reset mid-inference kills the run immediately; after release the block waits for a fresh `start`.
- `start` high at edge E0 (cycle 0 ends), giving this cycle-by-cycle sequence:
  - cycle 1: CLEAR.
  - cycle 2: BIAS with `rd_addr`=0.
  - cycles 3…N_PIX+1: RUN, addresses 1…N_PIX−1.
  - cycle N_PIX+2: DRAIN.
  - cycle N_PIX+3 onward: VALID.
- `mac_en` is high on cycles 3…N_PIX+2. For N_PIX=784: `mac_en` on cycles 3–786, `out_valid` from cycle 787.
- `out_valid` never drops without `out_ready`. With `out_ready` tied 1, `out_valid` lasts exactly one cycle and `busy` falls the following cycle.
- Minimum start-to-start spacing: N_PIX+4 cycles.

## Structure
- Shared package `l1_pkg`:
  - `N_PIX` default and `ADDR_W`.
  - 3-bit state encoding constants (IDLE, CLEAR, BIAS, RUN, DRAIN, VALID), shared with the top-level controller and testbench.
- Single module; the counter and `rd_vld` pipeline stay inline. No sub-module is warranted.

## Test plan
- Reset then idle: hold `rst`=0 for 3 cycles, then release. All outputs are 0 and `busy`=0 for 10 cycles with no `start`.
- Full run, N_PIX=784, `out_ready`=1:
  - `mac_clr` on cycle 1 and `mac_init_bias` on cycle 2.
  - 784 `mac_en` pulses with `rd_addr` 0…783, each address appearing exactly one cycle before its `mac_en`.
  - `out_valid` on cycle 787 only.
  - With a behavioural MAC model, weights = 1, pixels = 1, bias = 0: every accumulator equals 784.
- Backpressure: `out_ready`=0 for 20 cycles in VALID → `out_valid` stays 1, no MAC control pulses, `start` is ignored. Raising `out_ready` returns the FSM to IDLE the next cycle.
- Abort in RUN at `rd_addr`=100 → next cycle: state IDLE and `mac_en`=0. A new `start` gives a clean full run.
- Async reset asserted mid-RUN between clock edges → outputs 0 immediately, without waiting for a clock edge.
- Small config, N_PIX=2: `mac_en` exactly 2 cycles (cycles 3–4) and `out_valid` at cycle 5.

Source files
------------

// File: rtl/l1_mac_sequencer_pkg.sv
// Shared definitions for the layer-1 MAC sequencer: default sizes and the
// 3-bit state encoding also used by the top-level controller and testbench.
package l1_pkg;

  localparam int L1_N_PIX  = 784;
  localparam int L1_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_BIAS  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_VALID = 3'd5
  } state_e;

endpackage

// File: rtl/l1_mac_sequencer_if.sv
// Control/handshake bundle between the inference controller, the sequencer,
// the pixel/weight memories and the MAC array control inputs.
interface l1_mac_sequencer_if
  import l1_pkg::*;
#(
  parameter int ADDR_W = L1_ADDR_W
) ();

  logic              start;
  logic              abort;
  logic              out_ready;
  logic              busy;
  logic [ADDR_W-1:0] rd_addr;
  logic              mac_clr;
  logic              mac_init_bias;
  logic              mac_en;
  logic              out_valid;

  modport master (
    output start, abort, out_ready,
    input  busy, rd_addr, mac_clr, mac_init_bias, mac_en, out_valid
  );

  modport slave (
    input  start, abort, out_ready,
    output busy, rd_addr, mac_clr, mac_init_bias, mac_en, out_valid
  );

endinterface

// File: rtl/l1_mac_sequencer.sv
// Walks the layer-1 MAC array through one inference: clear, bias load,
// N_PIX address issues with a one-cycle read-valid pipeline, then result handoff.
module l1_mac_sequencer
  import l1_pkg::*;
#(
  parameter int N_PIX  = L1_N_PIX,
  parameter int ADDR_W = L1_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  l1_mac_sequencer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_vld_q, rd_vld_d;
  logic              mac_clr_d;
  logic              mac_init_bias_d;
  logic              out_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rd_addr_d       = rd_addr_q;
    rd_vld_d        = 1'b0;
    mac_clr_d       = 1'b0;
    mac_init_bias_d = 1'b0;
    out_valid_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        mac_clr_d = 1'b1;
        state_d   = ST_BIAS;
      end
      ST_BIAS: begin
        mac_init_bias_d = 1'b1;
        rd_addr_d       = '0;
        cnt_d           = ADDR_W'(1);
        rd_vld_d        = 1'b1;
        state_d         = ST_RUN;
      end
      ST_RUN: begin
        rd_addr_d = cnt_q;
        cnt_d     = cnt_q + ADDR_W'(1);
        rd_vld_d  = 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_VALID;
      end
      ST_VALID: begin
        out_valid_d = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort must also suppress the mac_en that the pending read would produce.
    if (bus.abort) begin
      state_d  = ST_IDLE;
      rd_vld_d = 1'b0;
    end
  end

  // Address is presented combinationally in the issuing cycle and held afterwards.
  assign bus.rd_addr       = rd_addr_d;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.mac_clr       = mac_clr_d;
  assign bus.mac_init_bias = mac_init_bias_d;
  assign bus.mac_en        = rd_vld_q;
  assign bus.out_valid     = out_valid_d;

endmodule

// File: tb/tb_l1_mac_sequencer.sv
// Directed bench for l1_mac_sequencer: a full-size instance with a behavioural
// MAC array and memories, plus a minimal N_PIX=2 instance.
module tb_l1_mac_sequencer;
  import l1_pkg::*;

  localparam int N    = 784;
  localparam int AW   = 10;
  localparam int NEUR = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  l1_mac_sequencer_if #(.ADDR_W(AW)) if0 ();
  l1_mac_sequencer_if #(.ADDR_W(AW)) if1 ();

  l1_mac_sequencer #(.N_PIX(N), .ADDR_W(AW)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  l1_mac_sequencer #(.N_PIX(2), .ADDR_W(AW)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories (1-cycle read) and MAC array driven by dut0.
  logic [7:0] pix_mem [0:N-1];
  logic [7:0] w_mem   [0:N-1][0:NEUR-1];
  logic [7:0] pix_q;
  logic [7:0] w_q     [0:NEUR-1];
  int         acc     [0:NEUR-1];

  initial begin
    for (int a = 0; a < N; a++) begin
      pix_mem[a] = 8'd1;
      for (int n = 0; n < NEUR; n++) w_mem[a][n] = 8'd1;
    end
    for (int n = 0; n < NEUR; n++) acc[n] = 0;
  end

  always @(posedge clk) begin
    pix_q <= pix_mem[if0.rd_addr];
    for (int n = 0; n < NEUR; n++) begin
      w_q[n] <= w_mem[if0.rd_addr][n];
      if (if0.mac_clr)            acc[n] <= 0;
      else if (if0.mac_init_bias) acc[n] <= 0;
      else if (if0.mac_en)        acc[n] <= acc[n] + int'(pix_q) * int'(w_q[n]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if0.busy, if0.mac_clr, if0.mac_init_bias, if0.mac_en, if0.out_valid, if0.rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_hold dut0 got busy=%b clr=%b bias=%b en=%b vld=%b addr=%0d want all 0",
               if0.busy, if0.mac_clr, if0.mac_init_bias, if0.mac_en, if0.out_valid, if0.rd_addr);
    end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({if0.busy, if0.mac_clr, if0.mac_init_bias, if0.mac_en, if0.out_valid, if0.rd_addr} !== '0) begin
        errors++;
        $display("FAIL idle0 cyc %0d got busy=%b clr=%b bias=%b en=%b vld=%b addr=%0d want all 0", c,
                 if0.busy, if0.mac_clr, if0.mac_init_bias, if0.mac_en, if0.out_valid, if0.rd_addr);
      end
      checks++;
      if ({if1.busy, if1.mac_clr, if1.mac_init_bias, if1.mac_en, if1.out_valid, if1.rd_addr} !== '0) begin
        errors++;
        $display("FAIL idle1 cyc %0d got busy=%b clr=%b bias=%b en=%b vld=%b addr=%0d want all 0", c,
                 if1.busy, if1.mac_clr, if1.mac_init_bias, if1.mac_en, if1.out_valid, if1.rd_addr);
      end
    end
  endtask

  task automatic test_full_run(input string tag);
    logic [4:0]    exp_ctl;
    logic [4:0]    got_ctl;
    logic [AW-1:0] prev_addr;
    int            en_cnt;
    en_cnt        = 0;
    prev_addr     = '0;
    if0.out_ready = 1'b1;
    if0.start     = 1'b1;
    step();
    if0.start = 1'b0;
    for (int cyc = 1; cyc <= N + 4; cyc++) begin
      exp_ctl = {(cyc <= N + 3), (cyc == 1), (cyc == 2), (cyc >= 3 && cyc <= N + 2), (cyc == N + 3)};
      got_ctl = {if0.busy, if0.mac_clr, if0.mac_init_bias, if0.mac_en, if0.out_valid};
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl cyc %0d got busy/clr/bias/en/vld=%b want %b", tag, cyc, got_ctl, exp_ctl);
      end
      if (cyc >= 2 && cyc <= N + 1) begin
        checks++;
        if (if0.rd_addr !== AW'(cyc - 2)) begin
          errors++;
          $display("FAIL %s rd_addr cyc %0d got %0d want %0d", tag, cyc, if0.rd_addr, cyc - 2);
        end
      end
      if (if0.mac_en === 1'b1) begin
        checks++;
        if (prev_addr !== AW'(en_cnt)) begin
          errors++;
          $display("FAIL %s addr_before_en cyc %0d got %0d want %0d", tag, cyc, prev_addr, en_cnt);
        end
        en_cnt++;
      end
      prev_addr = if0.rd_addr;
      if (cyc < N + 4) step();
    end
    checks++;
    if (en_cnt != N) begin
      errors++;
      $display("FAIL %s en_count got %0d want %0d", tag, en_cnt, N);
    end
    for (int n = 0; n < NEUR; n++) begin
      checks++;
      if (acc[n] != N) begin
        errors++;
        $display("FAIL %s acc[%0d] got %0d want %0d", tag, n, acc[n], N);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] got_ctl;
    if0.out_ready = 1'b0;
    if0.start     = 1'b1;
    step();
    if0.start = 1'b0;
    for (int i = 0; i < N + 10 && if0.out_valid !== 1'b1; i++) step();
    checks++;
    if (if0.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_reached got %b want 1", if0.out_valid);
    end
    for (int k = 0; k < 20; k++) begin
      if0.start = 1'b1;
      step();
      got_ctl = {if0.busy, if0.mac_clr, if0.mac_init_bias, if0.mac_en, if0.out_valid};
      checks++;
      if (got_ctl !== 5'b10001) begin
        errors++;
        $display("FAIL bp_hold k %0d got busy/clr/bias/en/vld=%b want 10001", k, got_ctl);
      end
    end
    if0.start     = 1'b0;
    if0.out_ready = 1'b1;
    step();
    checks++;
    if ({if0.busy, if0.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_release got busy=%b vld=%b want 0 0", if0.busy, if0.out_valid);
    end
    step();
    checks++;
    if ({if0.busy, if0.mac_clr} !== 2'b00) begin
      errors++;
      $display("FAIL bp_no_queue got busy=%b clr=%b want 0 0", if0.busy, if0.mac_clr);
    end
    checks++;
    if (acc[0] != N) begin
      errors++;
      $display("FAIL bp_acc_kept got %0d want %0d", acc[0], N);
    end
  endtask

  task automatic test_abort();
    if0.out_ready = 1'b1;
    if0.start     = 1'b1;
    step();
    if0.start = 1'b0;
    for (int i = 0; i < 200 && if0.rd_addr !== AW'(100); i++) step();
    checks++;
    if (if0.rd_addr !== AW'(100) || if0.mac_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach got addr=%0d en=%b want 100 1", if0.rd_addr, if0.mac_en);
    end
    if0.abort = 1'b1;
    step();
    if0.abort = 1'b0;
    checks++;
    if ({if0.busy, if0.mac_en} !== 2'b00) begin
      errors++;
      $display("FAIL abort_next got busy=%b en=%b want 0 0", if0.busy, if0.mac_en);
    end
    step();
    checks++;
    if ({if0.busy, if0.mac_en, if0.mac_clr} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle got busy=%b en=%b clr=%b want 0 0 0", if0.busy, if0.mac_en, if0.mac_clr);
    end
    test_full_run("after_abort");
  endtask

  task automatic test_async_reset();
    if0.out_ready = 1'b1;
    if0.start     = 1'b1;
    step();
    if0.start = 1'b0;
    repeat (50) step();
    checks++;
    if ({if0.busy, if0.mac_en} !== 2'b11) begin
      errors++;
      $display("FAIL areset_pre got busy=%b en=%b want 1 1", if0.busy, if0.mac_en);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({if0.busy, if0.mac_clr, if0.mac_init_bias, if0.mac_en, if0.out_valid, if0.rd_addr} !== '0) begin
      errors++;
      $display("FAIL areset_now got busy=%b clr=%b bias=%b en=%b vld=%b addr=%0d want all 0",
               if0.busy, if0.mac_clr, if0.mac_init_bias, if0.mac_en, if0.out_valid, if0.rd_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({if0.busy, if0.mac_en} !== 2'b00) begin
        errors++;
        $display("FAIL areset_wait cyc %0d got busy=%b en=%b want 0 0", c, if0.busy, if0.mac_en);
      end
    end
  endtask

  task automatic test_small();
    logic [4:0] exp_tab [1:6];
    logic [4:0] got_ctl;
    exp_tab[1] = 5'b11000;
    exp_tab[2] = 5'b10100;
    exp_tab[3] = 5'b10010;
    exp_tab[4] = 5'b10010;
    exp_tab[5] = 5'b10001;
    exp_tab[6] = 5'b00000;
    if1.out_ready = 1'b1;
    if1.start     = 1'b1;
    step();
    if1.start = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      got_ctl = {if1.busy, if1.mac_clr, if1.mac_init_bias, if1.mac_en, if1.out_valid};
      checks++;
      if (got_ctl !== exp_tab[cyc]) begin
        errors++;
        $display("FAIL small ctl cyc %0d got busy/clr/bias/en/vld=%b want %b", cyc, got_ctl, exp_tab[cyc]);
      end
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (if1.rd_addr !== AW'(cyc - 2)) begin
          errors++;
          $display("FAIL small rd_addr cyc %0d got %0d want %0d", cyc, if1.rd_addr, cyc - 2);
        end
      end
      if (cyc < 6) step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    if0.start     = 1'b0;
    if0.abort     = 1'b0;
    if0.out_ready = 1'b0;
    if1.start     = 1'b0;
    if1.abort     = 1'b0;
    if1.out_ready = 1'b0;

    test_reset();
    test_full_run("full_run");
    test_backpressure();
    test_abort();
    test_async_reset();
    test_small();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
